// File: rtl/trap_controller_if.sv
// trap_controller_if
// Groups every non-clock/reset signal of the trap controller.
//   Core request side : exception_request/cause/pc, mret_request,
//                       interrupt_request/cause
//   Core CSR side     : core_csr_address/write_value/write_enable (in),
//                       core_csr_read_value (out)
//   CSR file side     : csr_address/write_value/write_enable (out),
//                       csr_read_value (in)
//   Status            : busy, done, taken, redirect_pc (out)
// slave  = the trap controller itself
// master = the surrounding core / CSR file environment
interface trap_controller_if;
    logic        exception_request;
    logic [30:0] exception_cause;
    logic [31:0] exception_pc;
    logic        mret_request;
    logic        interrupt_request;
    logic [30:0] interrupt_cause;
    logic [11:0] core_csr_address;
    logic [31:0] core_csr_write_value;
    logic        core_csr_write_enable;
    logic [31:0] core_csr_read_value;
    logic [11:0] csr_address;
    logic [31:0] csr_write_value;
    logic        csr_write_enable;
    logic [31:0] csr_read_value;
    logic        busy;
    logic        done;
    logic        taken;
    logic [31:0] redirect_pc;

    modport slave (
        input  exception_request, exception_cause, exception_pc,
        input  mret_request, interrupt_request, interrupt_cause,
        input  core_csr_address, core_csr_write_value, core_csr_write_enable,
        input  csr_read_value,
        output core_csr_read_value,
        output csr_address, csr_write_value, csr_write_enable,
        output busy, done, taken, redirect_pc
    );

    modport master (
        output exception_request, exception_cause, exception_pc,
        output mret_request, interrupt_request, interrupt_cause,
        output core_csr_address, core_csr_write_value, core_csr_write_enable,
        output csr_read_value,
        input  core_csr_read_value,
        input  csr_address, csr_write_value, csr_write_enable,
        input  busy, done, taken, redirect_pc
    );
endinterface

// File: rtl/trap_controller.sv
// trap_controller
// Sequences machine-mode trap entry (exception / enabled interrupt) and MRET
// through the CSR file port, one CSR access per cycle.
// Ports:
//   clock - sole clock, all state updates on posedge
//   reset - asynchronous, active-high
//   bus   - trap_controller_if.slave (requests, core CSR pass-through,
//           CSR file port, busy/done/taken/redirect_pc)
// While IDLE the core owns the CSR file port; in every other state the
// controller drives it and the core CSR inputs are ignored.
module trap_controller (
    input  logic             clock,
    input  logic             reset,
    trap_controller_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        IDLE,
        RD_MSTATUS,
        WR_MSTATUS,
        WR_MEPC,
        WR_MCAUSE,
        RD_MTVEC,
        RD_MEPC,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        mret_q;
    logic        interrupt_q;
    logic [30:0] cause_q;
    logic [31:0] pc_q;
    logic [31:0] mstatus_q;
    logic [31:0] redirect_q;
    logic        taken_q;

    logic        any_request;
    logic        interrupt_masked;
    logic [31:0] mstatus_trap;
    logic [31:0] mstatus_mret;

    assign any_request = bus.exception_request | bus.mret_request | bus.interrupt_request;

    // The masking decision is made while mstatus is still on the read bus,
    // so it looks at csr_read_value rather than the not-yet-loaded mstatus_q.
    assign interrupt_masked = interrupt_q & ~bus.csr_read_value[3];

    // Trap entry: MPIE <- MIE, MIE <- 0. MRET: MIE <- MPIE, MPIE <- 1.
    assign mstatus_trap = {mstatus_q[31:8], mstatus_q[3], mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
    assign mstatus_mret = {mstatus_q[31:8], 1'b1, mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mret_q      <= 1'b0;
            interrupt_q <= 1'b0;
            cause_q     <= '0;
            pc_q        <= '0;
            mstatus_q   <= '0;
            redirect_q  <= '0;
            taken_q     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    // Priority: exception > mret > interrupt.
                    if (any_request) begin
                        mret_q      <= ~bus.exception_request & bus.mret_request;
                        interrupt_q <= ~bus.exception_request & ~bus.mret_request;
                        cause_q     <= bus.exception_request ? bus.exception_cause
                                                             : bus.interrupt_cause;
                        pc_q        <= bus.exception_pc;
                    end
                end
                RD_MSTATUS: begin
                    mstatus_q <= bus.csr_read_value;
                    if (interrupt_masked) begin
                        taken_q <= 1'b0;
                    end
                end
                RD_MTVEC, RD_MEPC: begin
                    redirect_q <= bus.csr_read_value & ALIGN_MASK;
                    taken_q    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next           = state;
        bus.csr_address      = '0;
        bus.csr_write_value  = '0;
        bus.csr_write_enable = 1'b0;
        case (state)
            IDLE: begin
                bus.csr_address      = bus.core_csr_address;
                bus.csr_write_value  = bus.core_csr_write_value;
                bus.csr_write_enable = bus.core_csr_write_enable;
                if (any_request) begin
                    state_next = RD_MSTATUS;
                end
            end
            RD_MSTATUS: begin
                bus.csr_address = ADDR_MSTATUS;
                state_next      = interrupt_masked ? DONE : WR_MSTATUS;
            end
            WR_MSTATUS: begin
                bus.csr_address      = ADDR_MSTATUS;
                bus.csr_write_value  = mret_q ? mstatus_mret : mstatus_trap;
                bus.csr_write_enable = 1'b1;
                state_next           = mret_q ? RD_MEPC : WR_MEPC;
            end
            WR_MEPC: begin
                bus.csr_address      = ADDR_MEPC;
                bus.csr_write_value  = pc_q & ALIGN_MASK;
                bus.csr_write_enable = 1'b1;
                state_next           = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                bus.csr_address      = ADDR_MCAUSE;
                bus.csr_write_value  = {interrupt_q, cause_q};
                bus.csr_write_enable = 1'b1;
                state_next           = RD_MTVEC;
            end
            RD_MTVEC: begin
                bus.csr_address = ADDR_MTVEC;
                state_next      = DONE;
            end
            RD_MEPC: begin
                bus.csr_address = ADDR_MEPC;
                state_next      = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.core_csr_read_value = bus.csr_read_value;
    assign bus.busy                = (state != IDLE);
    assign bus.done                = (state == DONE);
    assign bus.taken               = taken_q;
    assign bus.redirect_pc         = redirect_q;
endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have no parameters; all CSR addresses are fixed: mstatus 12'h300, mtvec 12'h305, mepc 12'h341, mcause 12'h342.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, with ports listed as below.
  - clock  in  1  sole clock; all state updates on posedge
  - reset  in  1  asynchronous, active-high
  - exception_request  in  1  level; synchronous exception pending
  - exception_cause  in  31  exception code
  - exception_pc  in  32  PC of the faulting instruction
  - mret_request  in  1  level; MRET retiring
  - interrupt_request  in  1  level; machine interrupt pending (already masked by mie)
  - interrupt_cause  in  31  interrupt code (3/7/11)
  - core_csr_address  in  12  core CSR-instruction address
  - core_csr_write_value  in  32  core CSR write data
  - core_csr_write_enable  in  1  core CSR write strobe
  - core_csr_read_value  out  32  CSR read data returned to core
  - csr_address  out  12  to CSR file
  - csr_write_value  out  32  to CSR file
  - csr_write_enable  out  1  to CSR file
  - csr_read_value  in  32  combinational read data from CSR file
  - busy  out  1  high in every non-IDLE state
  - done  out  1  one-cycle completion pulse
  - taken  out  1  valid with done; 1 = redirect required
  - redirect_pc  out  32  valid with done; new PC, bits [1:0] = 0

Function
REQ-003 SHALL implement states IDLE, RD_MSTATUS, WR_MSTATUS, WR_MEPC, WR_MCAUSE, RD_MTVEC, RD_MEPC, DONE.
REQ-004 In IDLE: csr_address, csr_write_value and csr_write_enable SHALL equal their core_* counterparts combinationally; in all other states the controller drives them and the core_* inputs are ignored.
REQ-005 core_csr_read_value SHALL equal csr_read_value combinationally in every state.
REQ-006 Requests SHALL be sampled only in IDLE, with priority exception > mret > interrupt; on acceptance, latch kind, cause (exception_cause or interrupt_cause), interrupt flag and exception_pc, then go to RD_MSTATUS.
REQ-007 A core CSR write in the accept cycle SHALL pass through to the CSR file unchanged.
REQ-008 RD_MSTATUS SHALL drive csr_address=12'h300 with write_enable=0 and capture csr_read_value into mstatus_q.
REQ-009 For an interrupt with mstatus_q[3]=0, RD_MSTATUS SHALL be followed by DONE with taken=0 and no CSR writes.
REQ-010 Trap path (exception, or interrupt with MIE=1) SHALL sequence WR_MSTATUS, WR_MEPC, WR_MCAUSE, RD_MTVEC, DONE, with one state per cycle.
REQ-011 WR_MSTATUS (trap) SHALL write mstatus_q with bit7=mstatus_q[3], bit3=0, and all other bits unchanged.
REQ-012 WR_MEPC SHALL write {pc[31:2],2'b00}.
REQ-013 WR_MCAUSE SHALL write {interrupt_flag, cause}.
REQ-014 RD_MTVEC SHALL capture {csr_read_value[31:2],2'b00} as redirect_pc.
REQ-015 MRET path SHALL sequence RD_MSTATUS, WR_MSTATUS, RD_MEPC, DONE.
REQ-016 WR_MSTATUS (mret) SHALL write bit3=mstatus_q[7], bit7=1.
REQ-017 RD_MEPC SHALL capture {csr_read_value[31:2],2'b00} as redirect_pc.
REQ-018 DONE SHALL assert done=1 for exactly one cycle, with taken=1 for trap and mret paths, then return to IDLE.
REQ-019 Latency from the accept edge SHALL be: trap, done in the 6th cycle; mret, 4th cycle; masked interrupt, 2nd cycle.
REQ-020 Requesters SHALL hold their request until done and deassert it in the done cycle; requests seen outside IDLE SHALL have no effect.
REQ-021 redirect_pc and taken SHALL hold their value until the next DONE; outside DONE they are don't-care to consumers.

Reset
REQ-022 Reset SHALL force state=IDLE, busy=0, done=0, taken=0, redirect_pc=0 and mstatus_q=0 asynchronously.
REQ-023 A reset mid-sequence SHALL abandon the sequence; CSR writes already performed are not undone, and no done pulse is produced.

Verification
REQ-024 Exception, cause=2, pc=32'h0000_1234, mstatus=32'h0000_1808, mtvec=32'h0000_0101: writes are mstatus=32'h0000_1880, mepc=32'h0000_1234, mcause=32'h0000_0002; done occurs in cycle 6 with taken=1 and redirect_pc=32'h0000_0100.
REQ-025 Interrupt, cause=7, mstatus MIE=1: mcause=32'h8000_0007 and mstatus bit3 is cleared; with MIE=0, done occurs in cycle 2 with taken=0 and csr_write_enable never asserted.
REQ-026 mret with mstatus=32'h0000_1880 and mepc=32'h0000_2000: mstatus is written 32'h0000_1888; done occurs in cycle 4 with redirect_pc=32'h0000_2000.
REQ-027 exception_request, mret_request and interrupt_request all high in the same cycle: only the exception is processed; a core CSR write to 12'h340 in the accept cycle reaches the CSR file and is blocked while busy.
REQ-028 Reset asserted during WR_MEPC: busy=0 and done=0 immediately; a subsequent exception completes normally.
